// File: rtl/temporizador_jogada.sv
// -----------------------------------------------------------------------------
// temporizador_jogada
//
// Response-time watchdog for the memory-game datapath. Counts single-cycle
// ticks from the upstream prescaler while the player may answer and reports
// one of two outcomes: the player answered (with the elapsed tick count), or
// the time limit expired.
//
// Parameters
//   LIMITE       ticks until timeout, legal range 1 .. 2**LARGURA-1
//   LARGURA      width of the elapsed-tick counter
//   AVISO_MARGEM warning threshold in ticks before LIMITE (AVISO_EN only),
//                must be < LIMITE
//
// Ports
//   i_clock     system clock, rising edge
//   i_clr       asynchronous active-low reset
//   i_iniciar   synchronous start/restart request
//   i_cancelar  synchronous abort (highest priority)
//   i_jogada    player-answer strobe
//   i_tick      one-cycle enable from the prescaler carry-out
//   o_tempo     elapsed ticks of the current or last attempt
//   o_ativo     high while counting
//   o_concluiu  high once the player answered in time
//   o_esgotou   high once LIMITE was reached
//   o_aviso     (only with macro AVISO_EN) high while counting and
//               o_tempo >= LIMITE-AVISO_MARGEM
//
// Configuration macro: AVISO_EN adds the o_aviso port and its logic.
// -----------------------------------------------------------------------------
module temporizador_jogada #(
  parameter int LIMITE       = 250,
  parameter int LARGURA      = 8,
  parameter int AVISO_MARGEM = 50
) (
  input  logic               i_clock,
  input  logic               i_clr,
  input  logic               i_iniciar,
  input  logic               i_cancelar,
  input  logic               i_jogada,
  input  logic               i_tick,
  output logic [LARGURA-1:0] o_tempo,
  output logic               o_ativo,
  output logic               o_concluiu,
`ifdef AVISO_EN
  output logic               o_esgotou,
  output logic               o_aviso
`else
  output logic               o_esgotou
`endif
);

  // Elaboration-time guards on the parameter ranges.
  if (LIMITE < 1 || LIMITE > (2**LARGURA) - 1) begin : g_chk_limite
    $error("temporizador_jogada: LIMITE out of range");
  end
  if (AVISO_MARGEM >= LIMITE) begin : g_chk_margem
    $error("temporizador_jogada: AVISO_MARGEM must be < LIMITE");
  end

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CONTANDO  = 2'd1,
    CONCLUIDO = 2'd2,
    ESGOTADO  = 2'd3
  } estado_t;

  localparam logic [LARGURA-1:0] LIM    = LARGURA'(LIMITE);
  localparam logic [LARGURA-1:0] LIM_M1 = LARGURA'(LIMITE - 1);

  estado_t            r_estado;
  logic [LARGURA-1:0] r_tempo;

  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge i_clock or negedge i_clr) begin
    if (!i_clr) begin
      r_estado <= OCIOSO;
      r_tempo  <= '0;
    end else if (i_cancelar) begin
      r_estado <= OCIOSO;
      r_tempo  <= '0;
    end else if (i_iniciar) begin
      // Restart also discards any tick arriving in the same cycle.
      r_estado <= CONTANDO;
      r_tempo  <= '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          r_estado <= OCIOSO;
        end
        CONTANDO: begin
          // Answer wins over a coincident tick: tempo stays frozen.
          if (i_jogada) begin
            r_estado <= CONCLUIDO;
          end else if (i_tick) begin
            if (r_tempo == LIM_M1) begin
              r_estado <= ESGOTADO;
              r_tempo  <= LIM;
            end else begin
              r_tempo <= r_tempo + 1'b1;
            end
          end
        end
        CONCLUIDO, ESGOTADO: begin
          r_estado <= r_estado;
        end
        default: begin
          r_estado <= OCIOSO;
          r_tempo  <= '0;
        end
      endcase
    end
  end

  // Moore flags decoded straight from the state register.
  assign o_tempo    = r_tempo;
  assign o_ativo    = (r_estado == CONTANDO);
  assign o_concluiu = (r_estado == CONCLUIDO);
  assign o_esgotou  = (r_estado == ESGOTADO);

`ifdef AVISO_EN
  localparam logic [LARGURA-1:0] LIM_AVISO = LARGURA'(LIMITE - AVISO_MARGEM);

  logic w_aviso;
  assign w_aviso = (r_estado == CONTANDO) && (r_tempo >= LIM_AVISO);
  assign o_aviso = w_aviso;
`endif

endmodule

// File: tb/tb_temporizador_jogada.sv
// -----------------------------------------------------------------------------
// tb_temporizador_jogada
//
// Self-checking bench for temporizador_jogada (LIMITE=4). Applies a table of
// directed per-cycle vectors, a hand-written asynchronous reset sequence, an
// AVISO_EN sequence on a LIMITE=10 instance (only when the macro is defined),
// and random stimulus compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_temporizador_jogada;

  localparam int LIM  = 4;
  localparam int LARG = 8;

  logic            clk;
  logic            clr;
  logic            iniciar;
  logic            cancelar;
  logic            jogada;
  logic            tick;
  logic [LARG-1:0] tempo;
  logic            ativo;
  logic            concluiu;
  logic            esgotou;
`ifdef AVISO_EN
  logic            aviso;
  logic [LARG-1:0] tempo10;
  logic            ativo10;
  logic            concluiu10;
  logic            esgotou10;
  logic            aviso10;
`endif

  int checks = 0;
  int errors = 0;

  temporizador_jogada #(.LIMITE(LIM), .LARGURA(LARG), .AVISO_MARGEM(1)) dut (
    .i_clock   (clk),
    .i_clr     (clr),
    .i_iniciar (iniciar),
    .i_cancelar(cancelar),
    .i_jogada  (jogada),
    .i_tick    (tick),
    .o_tempo   (tempo),
    .o_ativo   (ativo),
    .o_concluiu(concluiu),
`ifdef AVISO_EN
    .o_esgotou (esgotou),
    .o_aviso   (aviso)
`else
    .o_esgotou (esgotou)
`endif
  );

`ifdef AVISO_EN
  temporizador_jogada #(.LIMITE(10), .LARGURA(LARG), .AVISO_MARGEM(3)) dut10 (
    .i_clock   (clk),
    .i_clr     (clr),
    .i_iniciar (iniciar),
    .i_cancelar(cancelar),
    .i_jogada  (jogada),
    .i_tick    (tick),
    .o_tempo   (tempo10),
    .o_ativo   (ativo10),
    .o_concluiu(concluiu10),
    .o_esgotou (esgotou10),
    .o_aviso   (aviso10)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ini, can, jog, tck;
    int   e_tempo;
    logic e_ativo, e_concl, e_esgot;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs, let one rising edge sample them, then return on the
  // following falling edge where outputs are stable.
  task automatic cycle(input logic ini, input logic can, input logic jog,
                       input logic tck);
    iniciar  = ini;
    cancelar = can;
    jogada   = jog;
    tick     = tck;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input int e_tempo,
                            input logic e_ativo, input logic e_concl,
                            input logic e_esgot);
    check({tag, ".tempo"},    32'(tempo),    32'(e_tempo));
    check({tag, ".ativo"},    32'(ativo),    32'(e_ativo));
    check({tag, ".concluiu"}, 32'(concluiu), 32'(e_concl));
    check({tag, ".esgotou"},  32'(esgotou),  32'(e_esgot));
  endtask

  function automatic vec_t v(input logic ini, input logic can, input logic jog,
                             input logic tck, input int t, input logic a,
                             input logic c, input logic e);
    vec_t r;
    r.ini = ini; r.can = can; r.jog = jog; r.tck = tck;
    r.e_tempo = t; r.e_ativo = a; r.e_concl = c; r.e_esgot = e;
    return r;
  endfunction

  // Behavioural model state for the random phase.
  int m_tempo;
  bit m_ativo, m_concl, m_esgot;

  initial begin
    //            ini can jog tck  tempo ativo concl esgot
    vecs.push_back(v(0, 0, 0, 0,   0, 0, 0, 0)); // idle
    vecs.push_back(v(0, 0, 0, 1,   0, 0, 0, 0)); // tick ignored in idle
    vecs.push_back(v(0, 0, 1, 0,   0, 0, 0, 0)); // jogada ignored in idle
    vecs.push_back(v(1, 0, 0, 0,   0, 1, 0, 0)); // start
    vecs.push_back(v(0, 0, 0, 1,   1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0,   1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 1,   2, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0,   2, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 1,   3, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0,   3, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 1,   4, 0, 0, 1)); // 4th tick -> timeout
    vecs.push_back(v(0, 0, 0, 1,   4, 0, 0, 1)); // held
    vecs.push_back(v(0, 0, 1, 0,   4, 0, 0, 1)); // jogada ignored
    vecs.push_back(v(1, 0, 0, 0,   0, 1, 0, 0)); // restart from ESGOTADO
    vecs.push_back(v(0, 0, 0, 1,   1, 1, 0, 0)); // back-to-back ticks
    vecs.push_back(v(0, 0, 0, 1,   2, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 1,   3, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 1,   3, 0, 1, 0)); // jogada + final tick
    vecs.push_back(v(0, 0, 0, 1,   3, 0, 1, 0)); // frozen
    vecs.push_back(v(1, 1, 0, 0,   0, 0, 0, 0)); // cancelar beats iniciar
    vecs.push_back(v(1, 0, 0, 0,   0, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 1,   1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 1,   2, 1, 0, 0));
    vecs.push_back(v(1, 0, 1, 0,   0, 1, 0, 0)); // iniciar + jogada restarts
    vecs.push_back(v(0, 0, 0, 1,   1, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0,   1, 0, 1, 0)); // answer
    vecs.push_back(v(0, 0, 0, 1,   1, 0, 1, 0));
    vecs.push_back(v(1, 0, 0, 1,   0, 1, 0, 0)); // tick with iniciar dropped
    vecs.push_back(v(0, 1, 0, 0,   0, 0, 0, 0)); // cancel
    vecs.push_back(v(1, 0, 0, 0,   0, 1, 0, 0)); // answer scenario
    vecs.push_back(v(0, 0, 0, 1,   1, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 1,   2, 1, 0, 0));
    vecs.push_back(v(0, 0, 1, 0,   2, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 1,   2, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0,   0, 0, 0, 0));

    iniciar = 0; cancelar = 0; jogada = 0; tick = 0;
    clr = 0;
    repeat (2) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0);
    clr = 1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].ini, vecs[i].can, vecs[i].jog, vecs[i].tck);
      check_outs($sformatf("vec%0d", i), vecs[i].e_tempo, vecs[i].e_ativo,
                 vecs[i].e_concl, vecs[i].e_esgot);
    end

    // Asynchronous reset mid-count.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check_outs("prerst", 2, 1, 0, 0);
    #2 clr = 0;
    #1 check_outs("rst_async", 0, 0, 0, 0);
    tick = 1;
    @(posedge clk);
    #1 check_outs("rst_hold", 0, 0, 0, 0);
    @(negedge clk);
    clr = 1;
    cycle(0, 0, 0, 1);
    check_outs("rst_after_tick", 0, 0, 0, 0);

`ifdef AVISO_EN
    // Warning window on the LIMITE=10, AVISO_MARGEM=3 instance.
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check("aviso_t0", 32'(aviso10), 32'd0);
    for (int t = 1; t <= 10; t++) begin
      cycle(0, 0, 0, 1);
      check($sformatf("aviso10_tempo%0d", t), 32'(tempo10), 32'(t));
      check($sformatf("aviso_t%0d", t), 32'(aviso10), (t >= 7 && t <= 9) ? 32'd1 : 32'd0);
    end
    check("aviso_esgot", 32'(esgotou10), 32'd1);
    cycle(0, 1, 0, 0);
`endif

    // Random stimulus against the behavioural model.
    cycle(0, 1, 0, 0);
    m_tempo = 0; m_ativo = 0; m_concl = 0; m_esgot = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r_ini, r_can, r_jog, r_tck;
      r_can = ($urandom_range(39) == 0);
      r_ini = ($urandom_range(14) == 0);
      r_jog = ($urandom_range(11) == 0);
      r_tck = ($urandom_range(1) == 0);
      cycle(r_ini, r_can, r_jog, r_tck);
      if (r_can) begin
        m_tempo = 0; m_ativo = 0; m_concl = 0; m_esgot = 0;
      end else if (r_ini) begin
        m_tempo = 0; m_ativo = 1; m_concl = 0; m_esgot = 0;
      end else if (m_ativo) begin
        if (r_jog) begin
          m_ativo = 0; m_concl = 1;
        end else if (r_tck) begin
          m_tempo = m_tempo + 1;
          if (m_tempo == LIM) begin
            m_ativo = 0; m_esgot = 1;
          end
        end
      end
      check($sformatf("rand%0d", n), {21'd0, ativo, concluiu, esgotou, tempo},
            {21'd0, 1'(m_ativo), 1'(m_concl), 1'(m_esgot), LARG'(m_tempo)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
